// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// picorv32 native memory bus: one request/response channel.
//   valid  : request strobe, held with instr/addr/wdata/wstrb until ready
//   instr  : instruction fetch qualifier
//   addr   : byte address
//   wdata  : write data
//   wstrb  : byte strobes, 4'b0000 = read
//   ready  : one-cycle completion pulse
//   rdata  : read data, valid while ready=1
// Modports:
//   master : the side that issues requests (CPU, loader, or the arbiter
//            towards the shared slave)
//   slave  : the side that answers requests (the arbiter towards each master,
//            or the address decoder)
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Two-master round-robin arbiter sharing one picorv32 native-bus slave port
// between the CPU (m0) and a second master (m1, loader/DMA). One transaction
// in flight; a mandatory IDLE cycle separates transactions so a registered
// slave never sees a stale valid after its ready pulse.
//
// Optional feature: define ARB_TIMEOUT_EN to enable the watchdog that
// force-completes a transaction after TIMEOUT_CYCLES BUSY cycles without
// s_ready, returning TIMEOUT_RDATA and setting the sticky timeout_flag.
//
// Parameters:
//   TIMEOUT_CYCLES : BUSY cycles without s_ready before forced completion
//   TIMEOUT_RDATA  : read data returned on a forced completion
// Ports:
//   clock        : system clock
//   reset        : synchronous, active-high reset
//   m0, m1       : master request channels (arbiter acts as their slave)
//   s            : shared slave channel (arbiter acts as its master)
//   grant        : one-hot owner of the slave port, [0]=m0 [1]=m1, 0 when idle
//   timeout_flag : sticky, a transaction was force-completed
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; s_valid=0; picks a winner if any master requests
// BUSY  | granted master's request presented to the slave until s_ready
//       | (or watchdog expiry)
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic              clock,
    input  logic              reset,
    mem_bus_arbiter_if.slave  m0,
    mem_bus_arbiter_if.slave  m1,
    mem_bus_arbiter_if.master s,
    output logic [1:0]        grant,
    output logic              timeout_flag
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  grant_q;
    logic        last_grant_q;   // 0: m0 was served last, 1: m1
    logic        req_any;
    logic        pick_m1;
    logic        timeout_hit;
    logic        done;
    logic [31:0] resp_rdata;

    assign req_any = m0.valid | m1.valid;
    // With both requesting, the master not served last wins.
    assign pick_m1 = m1.valid & (~m0.valid | ~last_grant_q);
    assign done    = (state_q == BUSY) & (s.ready | timeout_hit);
    assign grant   = grant_q;

`ifdef ARB_TIMEOUT_EN
    // Down-counter loaded on entry to BUSY; reaching zero marks the
    // TIMEOUT_CYCLES-th BUSY cycle.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             timeout_flag_q;

    // A slave ready in the terminal cycle takes priority over the watchdog.
    assign timeout_hit  = (state_q == BUSY) & (tmo_cnt_q == '0) & ~s.ready;
    assign timeout_flag = timeout_flag_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt_q      <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            if (state_q == IDLE && req_any) begin
                tmo_cnt_q <= CNT_LOAD;
            end else if (state_q == BUSY && !done) begin
                tmo_cnt_q <= tmo_cnt_q - 1'b1;
            end
            if (timeout_hit) begin
                timeout_flag_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_any) begin
                grant_q <= pick_m1 ? 2'b10 : 2'b01;
            end else if (done) begin
                grant_q      <= 2'b00;
                last_grant_q <= grant_q[1];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = BUSY;
            BUSY:    if (done)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        s.valid    = 1'b0;
        s.instr    = 1'b0;
        s.addr     = 32'h0;
        s.wdata    = 32'h0;
        s.wstrb    = 4'h0;
        m0.ready   = 1'b0;
        m0.rdata   = 32'h0;
        m1.ready   = 1'b0;
        m1.rdata   = 32'h0;
        resp_rdata = s.ready ? s.rdata : TIMEOUT_RDATA;
        if (state_q == BUSY) begin
            s.valid = 1'b1;
            if (grant_q[1]) begin
                s.instr  = m1.instr;
                s.addr   = m1.addr;
                s.wdata  = m1.wdata;
                s.wstrb  = m1.wstrb;
                m1.ready = done;
                m1.rdata = done ? resp_rdata : 32'h0;
            end else begin
                s.instr  = m0.instr;
                s.addr   = m0.addr;
                s.wdata  = m0.wdata;
                s.wstrb  = m0.wstrb;
                m0.ready = done;
                m0.rdata = done ? resp_rdata : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    localparam int unsigned TO = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] grant;
    logic       timeout_flag;

    mem_bus_arbiter_if m0_if ();
    mem_bus_arbiter_if m1_if ();
    mem_bus_arbiter_if s_if ();

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .m0          (m0_if),
        .m1          (m1_if),
        .s           (s_if),
        .grant       (grant),
        .timeout_flag(timeout_flag)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_m(input int i, input logic v, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        if (i == 0) begin
            m0_if.valid = v; m0_if.instr = ins; m0_if.addr = a; m0_if.wdata = wd; m0_if.wstrb = ws;
        end else begin
            m1_if.valid = v; m1_if.instr = ins; m1_if.addr = a; m1_if.wdata = wd; m1_if.wstrb = ws;
        end
    endtask

    task automatic idle_inputs();
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        s_if.ready = 1'b0;
        s_if.rdata = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        idle_inputs();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One transaction from the cycle after the request is visible:
    // lat BUSY cycles without s_ready, then s_ready with rd, then the IDLE gap.
    task automatic xact(input int own, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] rd, input int lat, input bit drop);
        logic [1:0] eg;
        logic       own_rdy, oth_rdy;
        logic [31:0] own_rd, oth_rd;
        eg = (own == 1) ? 2'b10 : 2'b01;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clock);
            if (k == lat) begin
                s_if.ready = 1'b1;
                s_if.rdata = rd;
            end
            #1;
            own_rdy = (own == 1) ? m1_if.ready : m0_if.ready;
            oth_rdy = (own == 1) ? m0_if.ready : m1_if.ready;
            own_rd  = (own == 1) ? m1_if.rdata : m0_if.rdata;
            oth_rd  = (own == 1) ? m0_if.rdata : m1_if.rdata;
            chk("busy_s_valid", 32'(s_if.valid), 32'd1);
            chk("busy_grant", 32'(grant), 32'(eg));
            chk("busy_s_addr", s_if.addr, addr);
            chk("busy_s_wdata", s_if.wdata, wd);
            chk("busy_s_wstrb", 32'(s_if.wstrb), 32'(ws));
            chk("other_ready", 32'(oth_rdy), 32'd0);
            chk("other_rdata", oth_rd, 32'h0);
            if (k < lat) begin
                chk("owner_ready_wait", 32'(own_rdy), 32'd0);
                chk("owner_rdata_wait", own_rd, 32'h0);
            end else begin
                chk("owner_ready_done", 32'(own_rdy), 32'd1);
                chk("owner_rdata_done", own_rd, rd);
            end
        end
        @(negedge clock);
        s_if.ready = 1'b0;
        s_if.rdata = 32'h0;
        if (drop) begin
            m0_if.valid = 1'b0;
            m1_if.valid = 1'b0;
        end
        #1;
        chk("gap_grant", 32'(grant), 32'd0);
        chk("gap_s_valid", 32'(s_if.valid), 32'd0);
        chk("gap_m0_ready", 32'(m0_if.ready), 32'd0);
        chk("gap_m1_ready", 32'(m1_if.ready), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Random-phase reference state (transaction-level view of the masters)
    bit          pend [2];
    logic [31:0] raddr[2];
    logic [31:0] rwd  [2];
    logic [3:0]  rws  [2];
    bit          rin  [2];
    bit          rdy_seen[2];

    initial begin
        logic [1:0] eg, prev_g;
        bit         prev_done, pv0, pv1, dn;
        int         last_owner, o, lat;

        idle_inputs();

        // Reset values and a single m0 read
        do_reset();
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s_valid", 32'(s_if.valid), 32'd0);
        chk("rst_m0_ready", 32'(m0_if.ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_if.ready), 32'd0);
        chk("rst_timeout_flag", 32'(timeout_flag), 32'd0);
        @(negedge clock);
        set_m(0, 1'b1, 1'b0, 32'h0800_0010, 32'h0, 4'h0);
        #1;
        chk("req_latency_s_valid", 32'(s_if.valid), 32'd0);
        xact(0, 32'h0800_0010, 32'h0, 4'h0, 32'h1234_5678, 1, 1'b1);

        // Simultaneous requests from reset, both held: m0,m1,m0,m1
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h0000_1000, 32'h1111_0000, 4'h0);
        set_m(1, 1'b1, 1'b1, 32'h0000_2000, 32'h2222_0000, 4'h0);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0)
                xact(0, 32'h0000_1000, 32'h1111_0000, 4'h0, 32'hC0DE_0000 + k, 0, (k == 3));
            else
                xact(1, 32'h0000_2000, 32'h2222_0000, 4'h0, 32'hC0DE_0000 + k, 0, (k == 3));
        end

        // m1 byte write while m0 idle
        @(negedge clock);
        set_m(1, 1'b1, 1'b0, 32'h3000_0004, 32'h0000_00A5, 4'b0001);
        xact(1, 32'h3000_0004, 32'h0000_00A5, 4'b0001, 32'h0BAD_F00D, 2, 1'b1);

        // Spurious s_ready while idle
        @(negedge clock);
        s_if.ready = 1'b1;
        s_if.rdata = 32'h5555_AAAA;
        #1;
        chk("spur_m0_ready", 32'(m0_if.ready), 32'd0);
        chk("spur_m1_ready", 32'(m1_if.ready), 32'd0);
        chk("spur_m0_rdata", m0_if.rdata, 32'h0);
        chk("spur_grant", 32'(grant), 32'd0);
        @(negedge clock);
        s_if.ready = 1'b0;
        #1;
        chk("spur_after_grant", 32'(grant), 32'd0);
        chk("spur_after_s_valid", 32'(s_if.valid), 32'd0);

        // Reset during BUSY aborts without a ready pulse
        @(negedge clock);
        set_m(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
        @(negedge clock);
        #1;
        chk("abort_busy_grant", 32'(grant), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_m0_ready", 32'(m0_if.ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        m0_if.valid = 1'b0;
        #1;
        chk("abort_grant", 32'(grant), 32'd0);
        chk("abort_s_valid", 32'(s_if.valid), 32'd0);
        chk("abort_m0_ready_after", 32'(m0_if.ready), 32'd0);

`ifdef ARB_TIMEOUT_EN
        // Slave never answers: forced completion on the TO-th BUSY cycle
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0);
        for (int c = 1; c <= int'(TO); c++) begin
            @(negedge clock);
            #1;
            chk("to_grant", 32'(grant), 32'd1);
            if (c < int'(TO)) begin
                chk("to_wait_ready", 32'(m0_if.ready), 32'd0);
            end else begin
                chk("to_ready", 32'(m0_if.ready), 32'd1);
                chk("to_rdata", m0_if.rdata, 32'hDEAD_BEEF);
                chk("to_m1_ready", 32'(m1_if.ready), 32'd0);
            end
        end
        @(negedge clock);
        m0_if.valid = 1'b0;
        #1;
        chk("to_flag_set", 32'(timeout_flag), 32'd1);
        chk("to_idle_grant", 32'(grant), 32'd0);
        @(negedge clock);
        s_if.ready = 1'b1;
        s_if.rdata = 32'h7777_7777;
        #1;
        chk("to_late_m0_ready", 32'(m0_if.ready), 32'd0);
        chk("to_late_m1_ready", 32'(m1_if.ready), 32'd0);
        @(negedge clock);
        s_if.ready = 1'b0;
        #1;
        chk("to_flag_sticky", 32'(timeout_flag), 32'd1);
        chk("to_late_grant", 32'(grant), 32'd0);

        // s_ready on the terminal cycle wins over the watchdog
        do_reset();
        #1;
        chk("to2_flag_cleared", 32'(timeout_flag), 32'd0);
        set_m(0, 1'b1, 1'b0, 32'h0000_00C0, 32'h0, 4'h0);
        for (int c = 1; c <= int'(TO); c++) begin
            @(negedge clock);
            if (c == int'(TO)) begin
                s_if.ready = 1'b1;
                s_if.rdata = 32'h600D_CAFE;
            end
            #1;
            if (c < int'(TO)) chk("to2_wait_ready", 32'(m0_if.ready), 32'd0);
            else begin
                chk("to2_ready", 32'(m0_if.ready), 32'd1);
                chk("to2_rdata", m0_if.rdata, 32'h600D_CAFE);
            end
        end
        @(negedge clock);
        s_if.ready = 1'b0;
        m0_if.valid = 1'b0;
        #1;
        chk("to2_flag", 32'(timeout_flag), 32'd0);
        chk("to2_grant", 32'(grant), 32'd0);
`else
        // Without the watchdog a silent slave stalls the bus indefinitely
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clock);
            #1;
            chk("stall_grant", 32'(grant), 32'd1);
            chk("stall_m0_ready", 32'(m0_if.ready), 32'd0);
        end
        chk("stall_flag", 32'(timeout_flag), 32'd0);
        @(negedge clock);
        s_if.ready = 1'b1;
        s_if.rdata = 32'h600D_CAFE;
        #1;
        chk("stall_end_ready", 32'(m0_if.ready), 32'd1);
        chk("stall_end_rdata", m0_if.rdata, 32'h600D_CAFE);
        @(negedge clock);
        s_if.ready = 1'b0;
        m0_if.valid = 1'b0;
        #1;
        chk("stall_end_grant", 32'(grant), 32'd0);
        chk("stall_end_flag", 32'(timeout_flag), 32'd0);
`endif

        // Randomized traffic against a rule-level model
        do_reset();
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; rdy_seen[i] = 1'b0;
            raddr[i] = 32'h0; rwd[i] = 32'h0; rws[i] = 4'h0; rin[i] = 1'b0;
        end
        prev_g = 2'b00; prev_done = 1'b0; pv0 = 1'b0; pv1 = 1'b0;
        last_owner = 1; lat = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                if (rdy_seen[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    raddr[i] = $urandom;
                    rwd[i]   = $urandom;
                    rws[i]   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                    rin[i]   = 1'($urandom_range(0, 1));
                end
                set_m(i, pend[i], rin[i], raddr[i], rwd[i], rws[i]);
            end
            // Expected owner this cycle from the arbitration rules
            if (prev_done)          eg = 2'b00;
            else if (prev_g != 0)   eg = prev_g;
            else if (pv0 && pv1)    eg = (last_owner == 0) ? 2'b10 : 2'b01;
            else if (pv0)           eg = 2'b01;
            else if (pv1)           eg = 2'b10;
            else                    eg = 2'b00;
            if (eg != 0) begin
                if (lat == 0) begin
                    s_if.ready = 1'b1;
                    s_if.rdata = $urandom;
                end else begin
                    lat--;
                    s_if.ready = 1'b0;
                end
            end else begin
                s_if.ready = ($urandom_range(0, 7) == 0);
                s_if.rdata = $urandom;
                lat = $urandom_range(0, 3);
            end
            #1;
            o  = eg[1] ? 1 : 0;
            dn = (eg != 0) && s_if.ready;
            chk("rnd_grant", 32'(grant), 32'(eg));
            chk("rnd_s_valid", 32'(s_if.valid), 32'(eg != 0));
            if (eg != 0) begin
                chk("rnd_s_addr", s_if.addr, raddr[o]);
                chk("rnd_s_wdata", s_if.wdata, rwd[o]);
                chk("rnd_s_wstrb", 32'(s_if.wstrb), 32'(rws[o]));
                chk("rnd_s_instr", 32'(s_if.instr), 32'(rin[o]));
            end else begin
                chk("rnd_idle_s_addr", s_if.addr, 32'h0);
            end
            chk("rnd_m0_ready", 32'(m0_if.ready), 32'(dn && o == 0));
            chk("rnd_m1_ready", 32'(m1_if.ready), 32'(dn && o == 1));
            chk("rnd_m0_rdata", m0_if.rdata, (dn && o == 0) ? s_if.rdata : 32'h0);
            chk("rnd_m1_rdata", m1_if.rdata, (dn && o == 1) ? s_if.rdata : 32'h0);
            rdy_seen[0] = dn && (o == 0);
            rdy_seen[1] = dn && (o == 1);
            if (dn) last_owner = o;
            prev_done = dn;
            prev_g    = eg;
            pv0       = pend[0];
            pv1       = pend[1];
        end
        chk("rnd_flag", 32'(timeout_flag), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
